// File: rtl/serdes_var_pkg.sv
// serdes_var shared types: FSM states, mode flags, length-field width.
// Used by serdes_var and serdes_var_counter.
package serdes_var_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ALIGN = 2'd2
  } state_e;

  typedef struct packed {
    logic ser;
    logic des;
  } mode_t;

  function automatic int lb_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serdes_var_counter.sv
// serdes_var runtime-length step counter.
// Restart zeroes the count in the same cycle; is_last flags step k-1.
module serdes_var_counter #(
  parameter int LB = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          step,
  input  logic [LB-1:0] k,
  output logic          is_last,
  output logic          can_restart
);

  logic [LB-1:0] cnt_q, cnt_d, cnt;

  assign cnt         = restart ? '0 : cnt_q;
  assign is_last     = (cnt == k - LB'(1));
  assign can_restart = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt;
    if (step) cnt_d = is_last ? '0 : cnt + LB'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serdes_var.sv
// serdes_var: word stream <-> W*N buffer with runtime length k.
// SERDES_VAR_ALIGN_EN adds an ALIGN phase restoring word order.
module serdes_var
  import serdes_var_pkg::*;
#(
  parameter int W  = 64,
  parameter int N  = 4,
  parameter int LB = lb_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_startDes,
  input  logic          cmd_startSer,
  input  logic [LB-1:0] cmd_numWords,
  output logic          cmd_canReceive,
  input  logic [W*N-1:0] buffer_read,
  output logic [W*N-1:0] buffer_write,
  input  logic [W-1:0]  des,
  input  logic          des_isReady,
  output logic          des_canReceive,
  output logic          des_isLast,
  output logic [W-1:0]  ser,
  output logic          ser_isReady,
  input  logic          ser_canReceive,
  output logic          ser_isLast
);

  localparam int WN = W * N;
  localparam logic [LB-1:0] K_MAX = LB'(N);

  state_e        state_q, state_d;
  mode_t         mode_q, mode_d, mode;
  logic [LB-1:0] k_q, k_d, k, k_cmd;
  logic          accept, go, active, step;
  logic          last, done, can_restart, rotate;
`ifdef SERDES_VAR_ALIGN_EN
  logic [LB-1:0] rot_q, rot_d;
`endif

  assign cmd_canReceive = (state_q == ST_IDLE) & can_restart;
  assign accept = cmd_canReceive & (cmd_startSer | cmd_startDes);
  assign k_cmd  = (cmd_numWords > K_MAX) ? K_MAX : cmd_numWords;
  assign go     = accept & (k_cmd != '0);
  assign k      = go ? k_cmd : k_q;
  assign active = go | (state_q == ST_XFER);

  // The accepted command governs the bus already in its own cycle
  always_comb begin
    mode = mode_q;
    if (go) begin
      mode.ser = cmd_startSer;
      mode.des = cmd_startDes;
    end
  end

  always_comb begin
    step = 1'b0;
    if (active) begin
      if (mode.des & mode.ser) step = des_isReady & ser_canReceive;
      else if (mode.des)       step = des_isReady;
      else                     step = ser_canReceive;
    end
  end

  assign done = step & last;

  serdes_var_counter #(.LB(LB)) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .restart     (go),
    .step        (step),
    .k           (k),
    .is_last     (last),
    .can_restart (can_restart)
  );

  assign des_canReceive = mode.des & active & (mode.ser ? ser_canReceive : 1'b1);
  assign ser_isReady    = mode.ser & active & (mode.des ? des_isReady : ser_canReceive);
  assign des_isLast     = active & last;
  assign ser_isLast     = des_isLast;
  assign ser            = buffer_read[W-1:0];

`ifdef SERDES_VAR_ALIGN_EN
  assign rotate = (state_q == ST_ALIGN);
`else
  assign rotate = 1'b0;
`endif

  // Shift form keeps N=1 legal (no reversed part-selects)
  always_comb begin
    buffer_write = buffer_read;
    if (step & mode.des)
      buffer_write = WN'({des, buffer_read} >> W);
    else if (step | rotate)
      buffer_write = WN'({buffer_read[W-1:0], buffer_read} >> W);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    k_d     = k_q;
`ifdef SERDES_VAR_ALIGN_EN
    rot_d   = rot_q;
`endif
    if (go) begin
      mode_d  = mode;
      k_d     = k_cmd;
      state_d = ST_XFER;
    end
    if (done) begin
      state_d = ST_IDLE;
`ifdef SERDES_VAR_ALIGN_EN
      if (k < K_MAX) begin
        state_d = ST_ALIGN;
        rot_d   = K_MAX - k;
      end
`endif
    end
`ifdef SERDES_VAR_ALIGN_EN
    if (state_q == ST_ALIGN) begin
      rot_d = rot_q - LB'(1);
      if (rot_q == LB'(1)) state_d = ST_IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      k_q     <= '0;
`ifdef SERDES_VAR_ALIGN_EN
      rot_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
`ifdef SERDES_VAR_ALIGN_EN
      rot_q   <= rot_d;
`endif
    end
  end

endmodule

// File: tb/tb_serdes_var.sv
// Directed bench for serdes_var at W=8, N=4, with an external buffer.
// Expectations follow SERDES_VAR_ALIGN_EN when the build defines it.
module tb_serdes_var;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_startDes, cmd_startSer;
  logic [LB-1:0] cmd_numWords;
  logic          cmd_canReceive;
  logic [31:0]   buf_q = '0;
  logic [31:0]   buffer_write;
  logic [W-1:0]  des, ser;
  logic          des_isReady, des_canReceive, des_isLast;
  logic          ser_isReady, ser_canReceive, ser_isLast;
  logic          load = 1'b0;
  logic [31:0]   load_val = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    buf_q <= load ? load_val : buffer_write;

  serdes_var #(.W(W), .N(N), .LB(LB)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_startDes   (cmd_startDes),
    .cmd_startSer   (cmd_startSer),
    .cmd_numWords   (cmd_numWords),
    .cmd_canReceive (cmd_canReceive),
    .buffer_read    (buf_q),
    .buffer_write   (buffer_write),
    .des            (des),
    .des_isReady    (des_isReady),
    .des_canReceive (des_canReceive),
    .des_isLast     (des_isLast),
    .ser            (ser),
    .ser_isReady    (ser_isReady),
    .ser_canReceive (ser_canReceive),
    .ser_isLast     (ser_isLast)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic cr, input logic dc,
                      input logic sr, input logic lst);
    #1;
    chk({tag, " cmd_canReceive"}, 32'(cmd_canReceive), 32'(cr));
    chk({tag, " des_canReceive"}, 32'(des_canReceive), 32'(dc));
    chk({tag, " ser_isReady"}, 32'(ser_isReady), 32'(sr));
    chk({tag, " des_isLast"}, 32'(des_isLast), 32'(lst));
    chk({tag, " ser_isLast"}, 32'(ser_isLast), 32'(lst));
  endtask

  task automatic tick();
    @(negedge clk);
    cmd_startDes = 1'b0;
    cmd_startSer = 1'b0;
  endtask

  task automatic ld(input logic [31:0] v);
    load = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    cmd_startDes = 0; cmd_startSer = 0; cmd_numWords = 0;
    des = 0; des_isReady = 0; ser_canReceive = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    outs("reset", 1, 0, 0, 0);

    // 1: deserialise k=4
    ld(32'h01020304);
    cmd_startDes = 1; cmd_numWords = 4;
    des_isReady = 1; des = 8'h11;
    outs("s1 w0", 1, 1, 0, 0); tick();
    des = 8'h22; outs("s1 w1", 0, 1, 0, 0); tick();
    des = 8'h33; outs("s1 w2", 0, 1, 0, 0); tick();
    des = 8'h44; outs("s1 w3", 0, 1, 0, 1); tick();
    des_isReady = 0;
    outs("s1 end", 1, 0, 0, 0);
    chk("s1 buf", buf_q, 32'h44332211);

    // 2: serialise k=4, stall on 2nd cycle
    ld(32'hDDCCBBAA);
    cmd_startSer = 1; cmd_numWords = 4; ser_canReceive = 1;
    outs("s2 c0", 1, 0, 1, 0); chk("s2 ser0", 32'(ser), 32'hAA); tick();
    ser_canReceive = 0;
    outs("s2 stall", 0, 0, 0, 0); chk("s2 ser1", 32'(ser), 32'hBB); tick();
    ser_canReceive = 1;
    outs("s2 c2", 0, 0, 1, 0); chk("s2 ser2", 32'(ser), 32'hBB); tick();
    outs("s2 c3", 0, 0, 1, 0); chk("s2 ser3", 32'(ser), 32'hCC); tick();
    outs("s2 c4", 0, 0, 1, 1); chk("s2 ser4", 32'(ser), 32'hDD); tick();
    outs("s2 end", 1, 0, 0, 0);
    chk("s2 buf", buf_q, 32'hDDCCBBAA);

    // 3/4: short deserialise k=2
    ld(32'hDDCCBBAA);
    ser_canReceive = 0;
    cmd_startDes = 1; cmd_numWords = 2; des_isReady = 1; des = 8'h55;
    outs("s3 w0", 1, 1, 0, 0); tick();
    des = 8'h66; outs("s3 w1", 0, 1, 0, 1); tick();
`ifdef SERDES_VAR_ALIGN_EN
    des = 8'h99; ser_canReceive = 1;
    outs("s3 al0", 0, 0, 0, 0); tick();
    outs("s3 al1", 0, 0, 0, 0); tick();
    des_isReady = 0;
    outs("s3 end", 1, 0, 0, 0);
    chk("s3 buf", buf_q, 32'hDDCC6655);
`else
    des_isReady = 0;
    outs("s4 end", 1, 0, 0, 0);
    chk("s4 buf", buf_q, 32'h6655DDCC);
`endif

    // 5: exchange k=4, ser side toggles
    ld(32'hDDCCBBAA);
    cmd_startDes = 1; cmd_startSer = 1; cmd_numWords = 4;
    des_isReady = 1; des = 8'h01; ser_canReceive = 1;
    outs("s5 c0", 1, 1, 1, 0); chk("s5 ser0", 32'(ser), 32'hAA); tick();
    des = 8'h02; ser_canReceive = 0;
    outs("s5 c1", 0, 0, 1, 0); tick();
    ser_canReceive = 1;
    outs("s5 c2", 0, 1, 1, 0); chk("s5 ser1", 32'(ser), 32'hBB); tick();
    des = 8'h03;
    outs("s5 c3", 0, 1, 1, 0); chk("s5 ser2", 32'(ser), 32'hCC); tick();
    des = 8'h04; ser_canReceive = 0;
    outs("s5 c4", 0, 0, 1, 1); tick();
    ser_canReceive = 1;
    outs("s5 c5", 0, 1, 1, 1); chk("s5 ser3", 32'(ser), 32'hDD); tick();
    des_isReady = 0;
    outs("s5 end", 1, 0, 0, 0);
    chk("s5 buf", buf_q, 32'h04030201);

    // 6a: k=0 is a no-op
    cmd_startDes = 1; cmd_numWords = 0; des_isReady = 1; des = 8'hEE;
    outs("k0 c0", 1, 0, 0, 0); tick();
    outs("k0 c1", 1, 0, 0, 0);
    chk("k0 buf", buf_q, 32'h04030201);

    // 6b: k=7 clamps to 4; a command mid-transfer is ignored
    cmd_startDes = 1; cmd_numWords = 7; des = 8'hA1;
    outs("k7 w0", 1, 1, 0, 0); tick();
    cmd_startSer = 1; des = 8'hA2;
    outs("k7 w1", 0, 1, 0, 0); tick();
    des = 8'hA3; outs("k7 w2", 0, 1, 0, 0); tick();
    des = 8'hA4; outs("k7 w3", 0, 1, 0, 1); tick();
    des_isReady = 0;
    outs("k7 end", 1, 0, 0, 0);
    chk("k7 buf", buf_q, 32'hA4A3A2A1);

    // 6c: reset in the 2nd XFER cycle
    cmd_startDes = 1; cmd_numWords = 4; des_isReady = 1; des = 8'hB1;
    outs("rst w0", 1, 1, 0, 0); tick();
    rst = 1; des = 8'hB2; tick();
    rst = 0; ser_canReceive = 1;
    outs("rst after", 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serdes_var.md
# serdes_var

Word-serial to wide-buffer converter with runtime length. Moves between an external W·N-bit buffer and 64-bit-style word streams, deserialising, serialising, or both at once. Generalises the fixed-length serdes: word width, buffer depth and transfer count per command are all configurable. An optional alignment phase leaves the buffer in canonical word order after a short transfer. It sits between the Keccak/matrix datapaths and the word-stream buses.

## Interface
Parameters:
- W, default 64: word width in bits.
- N, default 4: buffer depth in words, N ≥ 1.
- LB, default $clog2(N+1): width of the length field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_startDes  in  1  request a deserialise.
- cmd_startSer  in  1  request a serialise. May be high together with cmd_startDes, which gives an exchange.
- cmd_numWords  in  LB  transfer count k. Sampled on accept; values above N are clamped to N.
- cmd_canReceive  out  1  block is idle and accepts a command.
- buffer_read  in  W·N  current buffer contents.
- buffer_write  out  W·N  next buffer contents.
- des  in  W  incoming word.
- des_isReady  in  1  incoming word is valid.
- des_canReceive  out  1  block takes `des` this cycle.
- des_isLast  out  1  the current transfer is the k-th.
- ser  out  W  outgoing word, always buffer_read[W-1:0].
- ser_isReady  out  1  `ser` is valid this cycle.
- ser_canReceive  in  1  downstream accepts a word.
- ser_isLast  out  1  equal to des_isLast.

## Operation
State machine:
- IDLE → XFER when a command is accepted: cmd_canReceive & (cmd_startSer | cmd_startDes) and k ≠ 0.
- A command with k = 0 is accepted and has no effect; the block stays IDLE.
- XFER → ALIGN after the k-th step when k < N and SERDES_VAR_ALIGN_EN is defined.
- XFER → IDLE after the k-th step otherwise.
- ALIGN → IDLE after N−k rotation steps.

Registers:
- Mode flags isSer and isDes.
- Step counter, LB bits.
- Remaining-rotation counter.

Command sampling: mode and k are captured on accept and also apply combinationally in the accept cycle, so a transfer may occur in the same cycle the command is accepted.

Step condition in XFER:
- isDes only: des_isReady.
- isSer only: ser_canReceive.
- Exchange (both flags): des_isReady & ser_canReceive.

Bus outputs:
- des_canReceive = isDes & active & (isSer ? ser_canReceive : 1).
- ser_isReady = isSer & active & (isDes ? des_isReady : ser_canReceive).
- des_isLast = active & (counter == k−1).

Buffer update:
- Deserialise step: buffer_write = {des, buffer_read[W·N-1:W]}.
- Serialise step: buffer_write = {buffer_read[W-1:0], buffer_read[W·N-1:W]}.
- ALIGN step: the same rotate as a serialise step, with no bus activity.
- No step: buffer_write = buffer_read.

Result after k deserialise steps plus alignment:
- Received word j is at word index j.
- Old words k..N−1 are unchanged.
- Serialise plus alignment leaves the buffer identical to its start.

## Timing
- Reset values:
  - state IDLE, both flags 0, both counters 0.
  - cmd_canReceive = 1.
  - des_canReceive, ser_isReady, des_isLast, ser_isLast = 0.
- Latency: k transfers take at least k cycles; stalls on either side add cycles one for one.
- ALIGN takes exactly N−k cycles; when k = N there is no ALIGN phase.
- cmd_canReceive is registered-state derived. It goes high the cycle after the last XFER or ALIGN step, never in the same cycle.
- Commands presented while cmd_canReceive is low are ignored, not queued.
- A rst pulse mid-XFER or mid-ALIGN returns the block to IDLE the next cycle. The buffer is left partially rotated; the owner must reload it.

## Configuration
SERDES_VAR_ALIGN_EN:
- Defined: the ALIGN phase is compiled in.
- Undefined: no ALIGN state or rotation counter. After k steps the buffer stays rotated by k words and the block returns to IDLE immediately.
- Full-length commands (k = N) behave identically either way.

## Structure
- Package serdes_var_pkg holds:
  - the state enum (IDLE, XFER, ALIGN);
  - the helper function for LB width;
  - the mode encoding.
- One sub-module, serdes_var_counter: the runtime-length step counter with restart, isLast and canRestart outputs.
- The top level contains the FSM and the buffer-write mux.

## Test plan
All scenarios use W=8, N=4.
1. Deserialise, k=4: des 0x11,0x22,0x33,0x44 on consecutive cycles → buffer = {0x44,0x33,0x22,0x11} (word 3 down to word 0); des_isLast only on 0x44; cmd_canReceive high one cycle after the last word.
2. Serialise, k=4, ser_canReceive low on the 2nd cycle: buffer {D,C,B,A} → ser emits A,B,C,D; ser_isReady low during the stall; the buffer ends identical to its start.
3. Short deserialise with SERDES_VAR_ALIGN_EN, k=2, buffer {D,C,B,A}, des 0x55 then 0x66 → buffer {D,C,0x66,0x55}; 2 ALIGN cycles with no bus activity; then IDLE.
4. Same stimulus as scenario 3 with the macro undefined → buffer {0x66,0x55,D,C}; cmd_canReceive high the cycle after 0x66.
5. Exchange, k=4: des 1,2,3,4 while ser_canReceive toggles → step only when both sides are ready; ser yields the old words A,B,C,D; buffer = {4,3,2,1}.
6. Edge cases:
   - cmd_numWords=0 → no transfer, cmd_canReceive stays 1.
   - cmd_numWords=7 → treated as 4.
   - rst asserted in the 2nd XFER cycle → all outputs at reset values the next cycle.
